encoder_emulator: RTL and testbench

ENCODER_EMULATOR -- requirements
Module: encoder_emulator

---
 rtl/encoder_emulator.sv | 137 +++++++++++++
 tb/tb_encoder_emulator.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/encoder_emulator.sv
// Rotary-encoder emulator: plays Gray-coded CLK/DT detent sequences and an optional
// active-low push-button pulse. Button generator is built only with ENCODER_EMULATOR_SW_EN.
module encoder_emulator #(
  parameter int PHASE_CYCLES    = 1000,
  parameter int SW_PRESS_CYCLES = 50000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       step_valid,
  input  logic       step_dir,
  input  logic [7:0] step_count,
  output logic       step_ready,
  output logic       step_done,
  input  logic       sw_req,
  output logic       enc_clk,
  output logic       enc_dt,
  output logic       enc_sw
);

  typedef enum logic [2:0] {IDLE, PH_A, PH_B, PH_C, DWELL} state_t;

  localparam logic [15:0] PH_LAST = 16'(PHASE_CYCLES - 1);

  state_t      r_state;
  state_t      w_nxt;
  logic [15:0] r_ph_cnt;
  logic [7:0]  r_rem;
  logic        r_dir;
  logic        r_ready;
  logic        r_done;
  logic        r_clk;
  logic        r_dt;
  logic        w_accept;
  logic        w_ph_end;

  // (clk,dt) for each phase; ni is shun with A/B swapped
  function automatic logic [1:0] f_lines(input state_t s, input logic dir);
    case (s)
      PH_A:    return dir ? 2'b10 : 2'b01;
      PH_B:    return 2'b11;
      PH_C:    return dir ? 2'b01 : 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Ready is forced low for the whole time reset is held
  assign step_ready = r_ready & ~sys_rst;
  assign step_done  = r_done;
  assign enc_clk    = r_clk;
  assign enc_dt     = r_dt;
  assign w_accept   = step_valid & step_ready;
  assign w_ph_end   = (r_ph_cnt == PH_LAST);

  always_comb begin
    w_nxt = IDLE;
    case (r_state)
      PH_A:    w_nxt = PH_B;
      PH_B:    w_nxt = PH_C;
      PH_C:    w_nxt = DWELL;
      DWELL:   w_nxt = (r_rem != 8'd0) ? PH_A : IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state  <= IDLE;
      r_ph_cnt <= '0;
      r_rem    <= '0;
      r_dir    <= 1'b0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_clk    <= 1'b0;
      r_dt     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (w_accept) begin
          r_dir    <= step_dir;
          r_ph_cnt <= '0;
          if (step_count != 8'd0) begin
            r_rem          <= step_count;
            r_state        <= PH_A;
            r_ready        <= 1'b0;
            {r_clk, r_dt}  <= f_lines(PH_A, step_dir);
          end else begin
            r_done <= 1'b1;
          end
        end
      end else if (w_ph_end) begin
        r_ph_cnt      <= '0;
        r_state       <= w_nxt;
        {r_clk, r_dt} <= f_lines(w_nxt, r_dir);
        // The step is counted as soon as the detent (DWELL) is reached
        if (w_nxt == DWELL)
          r_rem <= (r_rem != 8'd0) ? r_rem - 8'd1 : 8'd0;
        if (w_nxt == IDLE) begin
          r_done  <= 1'b1;
          r_ready <= 1'b1;
        end
      end else begin
        r_ph_cnt <= r_ph_cnt + 16'd1;
      end
    end
  end

`ifdef ENCODER_EMULATOR_SW_EN
  localparam logic [23:0] SW_LEN = 24'(SW_PRESS_CYCLES);

  logic [23:0] r_sw_cnt;
  logic        r_sw;

  // Requests arriving while a press is running are dropped, not queued
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_sw_cnt <= '0;
      r_sw     <= 1'b1;
    end else if (r_sw_cnt == 24'd0) begin
      if (sw_req) begin
        r_sw_cnt <= SW_LEN;
        r_sw     <= 1'b0;
      end
    end else begin
      r_sw_cnt <= r_sw_cnt - 24'd1;
      if (r_sw_cnt == 24'd1)
        r_sw <= 1'b1;
    end
  end

  assign enc_sw = r_sw;
`else
  logic w_sw_unused;
  assign w_sw_unused = sw_req;
  assign enc_sw      = 1'b1;
`endif

endmodule

// File: tb/tb_encoder_emulator.sv
// Scoreboard bench for encoder_emulator (PHASE_CYCLES=4, SW_PRESS_CYCLES=3).
module tb_encoder_emulator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       step_valid = 1'b0;
  logic       step_dir = 1'b0;
  logic [7:0] step_count = 8'd0;
  logic       step_ready, step_done;
  logic       sw_req = 1'b0;
  logic       enc_clk, enc_dt, enc_sw;

  int n_pass = 0;
  int n_total = 0;
  int n_ni = 0;
  int n_shun = 0;
  logic [4:0] sb_q[$];

  encoder_emulator #(.PHASE_CYCLES(4), .SW_PRESS_CYCLES(3)) dut (
    .sys_clk(clk), .sys_rst(rst), .step_valid(step_valid), .step_dir(step_dir),
    .step_count(step_count), .step_ready(step_ready), .step_done(step_done),
    .sw_req(sw_req), .enc_clk(enc_clk), .enc_dt(enc_dt), .enc_sw(enc_sw)
  );

  always #5 clk = ~clk;

  // Expected {clk,dt,ready,done,sw} at cycle T+k for a command accepted at T
  function automatic logic [4:0] exp_vec(input logic dir, input logic [7:0] cnt,
                                         input logic sw, input int k);
    int total;
    int ph;
    logic [1:0] ln;
    logic rdy, dn, esw;
    total = 16 * int'(cnt);
    if (k <= total) begin
      ph = ((k - 1) % 16) / 4;
      case (ph)
        0: ln = dir ? 2'b10 : 2'b01;
        1: ln = 2'b11;
        2: ln = dir ? 2'b01 : 2'b10;
        default: ln = 2'b00;
      endcase
      rdy = 1'b0;
      dn  = 1'b0;
    end else begin
      ln  = 2'b00;
      rdy = 1'b1;
      dn  = (k == total + 1);
    end
`ifdef ENCODER_EMULATOR_SW_EN
    esw = !(sw && k >= 1 && k <= 3);
`else
    esw = 1'b1;
`endif
    return {ln, rdy, dn, esw};
  endfunction

  // Accepts a command at the current cycle T and checks T+1..T+n.
  // A busy-time step_valid with other dir/count is poked at T+3; a second sw_req at T+2.
  task automatic run_cmd(input logic dir, input logic [7:0] cnt, input logic sw,
                         input int n, input string tag);
    logic [4:0] got, expv;
    logic [1:0] p, c;
    for (int k = 1; k <= n; k++) sb_q.push_back(exp_vec(dir, cnt, sw, k));
    p = {enc_clk, enc_dt};
    step_valid = 1'b1; step_dir = dir; step_count = cnt; sw_req = sw;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      got  = {enc_clk, enc_dt, step_ready, step_done, enc_sw};
      expv = sb_q.pop_front();
      n_total++;
      if (got !== expv)
        $display("FAIL %s k=%0d {clk,dt,rdy,done,sw} got=%b exp=%b", tag, k, got, expv);
      else
        n_pass++;
      c = {enc_clk, enc_dt};
      if (c[1] != p[1]) begin
        if (c[1]) begin if (c[0]) n_ni++; else n_shun++; end
        else begin if (c[0]) n_shun++; else n_ni++; end
      end
      p = c;
      step_valid = 1'b0; sw_req = 1'b0;
      if (k == 2 && sw) sw_req = 1'b1;
      if (k == 3 && cnt != 8'd0) begin
        step_valid = 1'b1; step_dir = ~dir; step_count = 8'd5;
      end
    end
    step_valid = 1'b0; sw_req = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_total++;
    if ({enc_clk, enc_dt, step_ready, step_done, enc_sw} !== 5'b00001)
      $display("FAIL reset_hold got=%b exp=00001", {enc_clk, enc_dt, step_ready, step_done, enc_sw});
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if ({enc_clk, enc_dt, step_ready, step_done, enc_sw} !== 5'b00101)
      $display("FAIL reset_release got=%b exp=00101", {enc_clk, enc_dt, step_ready, step_done, enc_sw});
    else n_pass++;
  endtask

  task automatic test_shun();
    run_cmd(1'b1, 8'd1, 1'b0, 18, "shun1");
  endtask

  task automatic test_ni();
    n_ni = 0; n_shun = 0;
    run_cmd(1'b0, 8'd2, 1'b0, 34, "ni2");
    n_total++;
    if (n_ni !== 4 || n_shun !== 0)
      $display("FAIL ni_decode got ni=%0d shun=%0d exp ni=4 shun=0", n_ni, n_shun);
    else n_pass++;
  endtask

  task automatic test_zero();
    run_cmd(1'b1, 8'd0, 1'b0, 3, "zero");
  endtask

  task automatic test_back_to_back();
    run_cmd(1'b1, 8'd1, 1'b0, 17, "b2b_first");
    run_cmd(1'b0, 8'd1, 1'b0, 18, "b2b_second");
  endtask

  task automatic test_sw();
    run_cmd(1'b1, 8'd1, 1'b1, 18, "sw_with_step");
  endtask

  task automatic test_abort();
    logic [4:0] got;
    run_cmd(1'b1, 8'd3, 1'b0, 6, "abort_pre");
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      got = {enc_clk, enc_dt, step_ready, step_done, enc_sw};
      n_total++;
      if (got !== 5'b00001) $display("FAIL abort_in_reset k=%0d got=%b exp=00001", k, got);
      else n_pass++;
    end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      got = {enc_clk, enc_dt, step_ready, step_done, enc_sw};
      n_total++;
      if (got !== 5'b00101) $display("FAIL abort_after k=%0d got=%b exp=00101", k, got);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_shun();
    test_ni();
    test_zero();
    test_back_to_back();
    test_sw();
    test_abort();
    test_shun();
    if (sb_q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
